// File: rtl/ay_pkg.sv
// Shared types and constants for the AY-3-8910 bus sequencer: FSM states, owners,
// {bdir,bc1} bus encodings and the power-up register image.
package ay_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADR,
    ST_GAP1,
    ST_WR,
    ST_RD,
    ST_GAP2
  } ay_state_e;

  typedef enum logic [1:0] {
    OWN_INIT,
    OWN_CPU,
    OWN_PLY
  } ay_owner_e;

  // {bdir, bc1}
  localparam logic [1:0] BUS_INACT = 2'b00;
  localparam logic [1:0] BUS_ADR   = 2'b11;
  localparam logic [1:0] BUS_WR    = 2'b10;
  localparam logic [1:0] BUS_RD    = 2'b01;

  localparam logic [3:0] AY_MIXER_REG  = 4'd7;
  localparam logic [7:0] AY_MIXER_INIT = 8'h3F;
  localparam int         AY_NUM_REGS   = 14;
  localparam logic [3:0] AY_LAST_REG   = 4'(AY_NUM_REGS - 1);

  localparam int CNT_W = 8;

  function automatic logic [7:0] ay_init_data(input logic [3:0] r);
    return (r == AY_MIXER_REG) ? AY_MIXER_INIT : 8'h00;
  endfunction

endpackage

// File: rtl/ay_seq_arb.sv
// Two-requester round-robin grant with last-granted memory; combinational grant,
// no backpressure of its own (requesters hold req until acked).
module ay_seq_arb (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic c_req,
  input  logic p_req,
  output logic gnt_c,
  output logic gnt_p
);

  logic last_p;

  always_comb begin
    gnt_c = en & c_req & (~p_req | last_p);
    gnt_p = en & p_req & (~c_req | ~last_p);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_p <= 1'b1;
    end else if (gnt_c) begin
      last_p <= 1'b0;
    end else if (gnt_p) begin
      last_p <= 1'b1;
    end
  end

endmodule

// File: rtl/ay_bus_seq.sv
// AY bus sequencer: runs a 14-register init image, then serves CPU and player requests.
// Latency T_ADR+T_GAP+T_STB+T_GAP from first ADR cycle to ack; requesters hold req until ack.
module ay_bus_seq
  import ay_pkg::*;
#(
  parameter int T_ADR = 4,
  parameter int T_STB = 4,
  parameter int T_GAP = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       c_req,
  input  logic       c_we,
  input  logic [3:0] c_reg,
  input  logic [7:0] c_wdata,
  output logic       c_ack,
  output logic [7:0] c_rdata,
  input  logic       p_req,
  input  logic [3:0] p_reg,
  input  logic [7:0] p_wdata,
  output logic       p_ack,
  output logic [7:0] ay_da_o,
  output logic       ay_da_oe,
  input  logic [7:0] ay_da_i,
  output logic       bdir,
  output logic       bc1,
  output logic       init_done
);

  ay_state_e        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       cur_reg;
  logic [7:0]       cur_data;
  logic             cur_we;
  ay_owner_e        cur_owner;
  logic [3:0]       init_idx;
  logic             gnt_c, gnt_p, arb_en;
  logic             ld_init, idx_inc, done_set;
  logic [3:0]       ld_reg;
  logic             last_cyc;

  assign last_cyc = (cnt == '0);
  assign arb_en   = (state == ST_IDLE) && init_done;

  ay_seq_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (arb_en),
    .c_req   (c_req),
    .p_req   (p_req),
    .gnt_c   (gnt_c),
    .gnt_p   (gnt_p)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Init writes run back to back: GAP2 of one flows straight into ADR of the next.
  always_comb begin
    state_d  = state;
    cnt_d    = last_cyc ? cnt : cnt - CNT_W'(1);
    ld_init  = 1'b0;
    ld_reg   = init_idx;
    idx_inc  = 1'b0;
    done_set = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        if (!init_done) begin
          ld_init = 1'b1;
          state_d = ST_ADR;
          cnt_d   = CNT_W'(T_ADR - 1);
        end else if (gnt_c || gnt_p) begin
          state_d = ST_ADR;
          cnt_d   = CNT_W'(T_ADR - 1);
        end
      end
      ST_ADR: if (last_cyc) begin
        state_d = ST_GAP1;
        cnt_d   = CNT_W'(T_GAP - 1);
      end
      ST_GAP1: if (last_cyc) begin
        state_d = cur_we ? ST_WR : ST_RD;
        cnt_d   = CNT_W'(T_STB - 1);
      end
      ST_WR, ST_RD: if (last_cyc) begin
        state_d = ST_GAP2;
        cnt_d   = CNT_W'(T_GAP - 1);
      end
      ST_GAP2: if (last_cyc) begin
        if (cur_owner == OWN_INIT && init_idx != AY_LAST_REG) begin
          state_d = ST_ADR;
          cnt_d   = CNT_W'(T_ADR - 1);
          ld_init = 1'b1;
          idx_inc = 1'b1;
          ld_reg  = init_idx + 4'd1;
        end else begin
          state_d  = ST_IDLE;
          done_set = (cur_owner == OWN_INIT);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_reg   <= '0;
      cur_data  <= '0;
      cur_we    <= 1'b0;
      cur_owner <= OWN_INIT;
      init_idx  <= '0;
      init_done <= 1'b0;
      c_rdata   <= '0;
    end else begin
      if (ld_init) begin
        cur_reg   <= ld_reg;
        cur_data  <= ay_init_data(ld_reg);
        cur_we    <= 1'b1;
        cur_owner <= OWN_INIT;
      end else if (gnt_c) begin
        cur_reg   <= c_reg;
        cur_data  <= c_wdata;
        cur_we    <= c_we;
        cur_owner <= OWN_CPU;
      end else if (gnt_p) begin
        cur_reg   <= p_reg;
        cur_data  <= p_wdata;
        cur_we    <= 1'b1;
        cur_owner <= OWN_PLY;
      end
      if (idx_inc) init_idx <= init_idx + 4'd1;
      if (done_set) init_done <= 1'b1;
      if (state == ST_RD && last_cyc && cur_owner == OWN_CPU) c_rdata <= ay_da_i;
    end
  end

  // Bus pins decode straight from state so reset idles the bus without waiting for a clock.
  always_comb begin
    {bdir, bc1} = BUS_INACT;
    ay_da_oe    = 1'b0;
    ay_da_o     = 8'h00;
    case (state)
      ST_ADR: begin
        {bdir, bc1} = BUS_ADR;
        ay_da_oe    = 1'b1;
        ay_da_o     = {4'h0, cur_reg};
      end
      ST_GAP1: begin
        ay_da_oe = 1'b1;
        ay_da_o  = {4'h0, cur_reg};
      end
      ST_WR: begin
        {bdir, bc1} = BUS_WR;
        ay_da_oe    = 1'b1;
        ay_da_o     = cur_data;
      end
      ST_RD: {bdir, bc1} = BUS_RD;
      default: ;
    endcase
  end

  assign c_ack = (state == ST_GAP2) && last_cyc && (cur_owner == OWN_CPU);
  assign p_ack = (state == ST_GAP2) && last_cyc && (cur_owner == OWN_PLY);

endmodule
